// File: rtl/pb_pkg.sv
// ============================================================================
//  Module   : pb_pkg
//  Purpose  : Shared widths and defaults for the pushbutton conditioner.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pb_pkg;
  localparam int PB_W             = 10;
  localparam int KEY_W            = 4;
  localparam int DEBOUNCE_DEFAULT = 50000;
endpackage

`default_nettype wire

// File: rtl/pb_debounce.sv
// ============================================================================
//  Module   : pb_debounce
//  Purpose  : One-bit 2-FF synchronizer followed by a stable-count debouncer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pb_debounce
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic nrst,
  input  logic raw,
  output logic stable,
  output logic stable_next
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // Any cycle where the synchronized level agrees with stable restarts the count.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync2_q;
      else                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable      = stable_q;
  assign stable_next = stable_d;

endmodule

`default_nettype wire

// File: rtl/pb_conditioner.sv
// ============================================================================
//  Module   : pb_conditioner
//  Purpose  : Debounced pushbuttons plus a 1-entry key event buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pb_conditioner
  import pb_pkg::*;
#(
  parameter int NUM_PB          = PB_W,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NUM_PB-1:0] pb_raw,
  output logic [NUM_PB-1:0] pb_clean,
  output logic              key_valid,
  output logic [KEY_W-1:0]  key_code,
  input  logic              key_ready,
  output logic              multi_press,
  output logic              overrun
);

  logic [NUM_PB-1:0] stable, stable_next, press;

  for (genvar g = 0; g < NUM_PB; g++) begin : g_pb
    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk         (clk),
      .nrst        (nrst),
      .raw         (pb_raw[g]),
      .stable      (stable[g]),
      .stable_next (stable_next[g])
    );
  end

  assign press    = stable_next & ~stable;
  assign pb_clean = stable;

  logic [KEY_W-1:0] enc;

  always_comb begin
    enc = '0;
    for (int i = NUM_PB - 1; i >= 0; i--) begin
      if (press[i]) enc = KEY_W'(i);
    end
  end

  logic             key_valid_q, key_valid_d;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             multi_q, multi_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    multi_d     = 1'b0;
    overrun_d   = 1'b0;
    if (|press) begin
      // Clearing the lowest set bit leaves something only if two or more were set.
      multi_d = |(press & (press - NUM_PB'(1)));
      if (!key_valid_q || key_ready) begin
        key_valid_d = 1'b1;
        key_code_d  = enc;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_ready) begin
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      multi_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      multi_q     <= multi_d;
      overrun_q   <= overrun_d;
    end
  end

  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign multi_press = multi_q;
  assign overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_pb_conditioner.sv
// ============================================================================
//  Module   : tb_pb_conditioner
//  Purpose  : Self-checking bench for pb_conditioner with DEBOUNCE_CYCLES=4.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pb_conditioner;

  localparam int NPB = 10;

  logic           clk = 1'b0;
  logic           nrst;
  logic [NPB-1:0] pb_raw;
  logic [NPB-1:0] pb_clean;
  logic           key_valid;
  logic [3:0]     key_code;
  logic           key_ready;
  logic           multi_press;
  logic           overrun;

  int errors = 0;
  int checks = 0;
  int mp_cnt = 0;
  int ov_cnt = 0;
  int exp_q[$];

  pb_conditioner #(.NUM_PB(NPB), .DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .pb_raw      (pb_raw),
    .pb_clean    (pb_clean),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .multi_press (multi_press),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Scoreboard: every handshake pops the oldest expected code.
  always @(negedge clk) begin
    if (multi_press) mp_cnt++;
    if (overrun)     ov_cnt++;
    if (nrst && key_valid && key_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event: got key_code=%0d, expected no event", key_code);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (key_code !== 4'(e)) begin
          errors++;
          $display("FAIL event_code: got %0d, expected %0d", key_code, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic release_all();
    pb_raw    = '0;
    key_ready = 1'b1;
    tick(8);
    chk("idle_clean", 32'(pb_clean), 32'h0);
    chk("idle_queue", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic test_reset();
    nrst = 1'b0; pb_raw = '0; key_ready = 1'b1;
    tick(3);
    chk("rst_clean",   32'(pb_clean),    32'h0);
    chk("rst_valid",   32'(key_valid),   32'h0);
    chk("rst_code",    32'(key_code),    32'h0);
    chk("rst_multi",   32'(multi_press), 32'h0);
    chk("rst_overrun", 32'(overrun),     32'h0);
    nrst = 1'b1;
    tick(2);
  endtask

  task automatic test_clean_press();
    exp_q.push_back(3);
    pb_raw[3] = 1'b1;
    tick(5);
    chk("clean_early_valid", 32'(key_valid), 32'h0);
    chk("clean_early_pb",    32'(pb_clean),  32'h0);
    tick(1);
    chk("clean_pb",    32'(pb_clean),  32'h008);
    chk("clean_valid", 32'(key_valid), 32'h1);
    chk("clean_code",  32'(key_code),  32'h3);
    tick(1);
    chk("clean_drain", 32'(key_valid), 32'h0);
    tick(5);
    release_all();
    chk("clean_release_valid", 32'(key_valid), 32'h0);
  endtask

  task automatic test_bounce();
    logic [5:0] seq;
    seq = 6'b101101;
    exp_q.push_back(5);
    for (int i = 5; i >= 0; i--) begin
      pb_raw[5] = seq[i];
      tick(1);
    end
    tick(4);
    chk("bounce_early_pb",    32'(pb_clean[5]), 32'h0);
    chk("bounce_early_valid", 32'(key_valid),   32'h0);
    tick(1);
    chk("bounce_pb",    32'(pb_clean[5]), 32'h1);
    chk("bounce_valid", 32'(key_valid),   32'h1);
    chk("bounce_code",  32'(key_code),    32'h5);
    tick(2);
    pb_raw[5] = 1'b0;
    tick(3);
    pb_raw[5] = 1'b1;
    tick(8);
    chk("glitch3_pb", 32'(pb_clean[5]), 32'h1);
    release_all();
  endtask

  task automatic test_simultaneous();
    int mp0;
    mp0 = mp_cnt;
    exp_q.push_back(2);
    pb_raw[7] = 1'b1;
    pb_raw[2] = 1'b1;
    tick(6);
    chk("simul_valid", 32'(key_valid),   32'h1);
    chk("simul_code",  32'(key_code),    32'h2);
    chk("simul_multi", 32'(multi_press), 32'h1);
    tick(1);
    chk("simul_multi_off", 32'(multi_press), 32'h0);
    chk("simul_multi_cnt", 32'(mp_cnt - mp0), 32'd1);
    release_all();
  endtask

  task automatic test_backpressure();
    int ov0;
    ov0 = ov_cnt;
    key_ready = 1'b0;
    exp_q.push_back(1);
    pb_raw[1] = 1'b1;
    tick(6);
    chk("bp_code1", 32'(key_code), 32'h1);
    pb_raw[8] = 1'b1;
    tick(6);
    chk("bp_overrun", 32'(overrun),   32'h1);
    chk("bp_hold",    32'(key_code),  32'h1);
    chk("bp_valid",   32'(key_valid), 32'h1);
    tick(1);
    chk("bp_overrun_off", 32'(overrun),       32'h0);
    chk("bp_overrun_cnt", 32'(ov_cnt - ov0),  32'd1);
    key_ready = 1'b1;
    tick(1);
    chk("bp_drain", 32'(key_valid), 32'h0);
    release_all();
  endtask

  task automatic test_back_to_back();
    int ov0;
    ov0 = ov_cnt;
    key_ready = 1'b0;
    exp_q.push_back(4);
    exp_q.push_back(9);
    pb_raw[4] = 1'b1;
    tick(6);
    chk("b2b_code4", 32'(key_code), 32'h4);
    pb_raw[9] = 1'b1;
    tick(5);
    key_ready = 1'b1;
    tick(1);
    chk("b2b_valid",   32'(key_valid), 32'h1);
    chk("b2b_code9",   32'(key_code),  32'h9);
    chk("b2b_overrun", 32'(overrun),   32'h0);
    tick(1);
    chk("b2b_drain",     32'(key_valid),     32'h0);
    chk("b2b_ovr_count", 32'(ov_cnt - ov0),  32'd0);
    release_all();
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(6);
    pb_raw[6] = 1'b1;
    tick(8);
    pb_raw[0] = 1'b1;
    tick(3);
    chk("rm_pre_clean", 32'(pb_clean), 32'h040);
    nrst = 1'b0;
    tick(1);
    chk("rm_clean", 32'(pb_clean),  32'h0);
    chk("rm_valid", 32'(key_valid), 32'h0);
    chk("rm_code",  32'(key_code),  32'h0);
    tick(2);
    exp_q.push_back(0);
    nrst = 1'b1;
    tick(5);
    chk("rm_early_valid", 32'(key_valid), 32'h0);
    tick(1);
    chk("rm_valid_after", 32'(key_valid),   32'h1);
    chk("rm_code_after",  32'(key_code),    32'h0);
    chk("rm_multi_after", 32'(multi_press), 32'h1);
    release_all();
  endtask

  initial begin
    nrst      = 1'b0;
    pb_raw    = '0;
    key_ready = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pb_conditioner.md
# pb_conditioner

Pushbutton input conditioning stage placed between the breakout-board GPIO inputs and the calculator core. It synchronizes the raw, asynchronous, bouncing buttons and debounces each one. It emits clean, level-stable button lines plus a single registered key event (code + valid/ready handshake) per press. Dropped presses are flagged rather than silently lost.

## Interface
- `NUM_PB`, 10: number of pushbutton inputs; must be ≤ 16.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a level change (5 ms at 10 MHz); must be ≥ 2.
- `clk`  in  1: system clock; single clock domain.
- `nrst`  in  1: reset, synchronous, active-low.
- `pb_raw`  in  NUM_PB: raw buttons from `gpio_in`, active-high, asynchronous.
- `pb_clean`  out  NUM_PB: debounced button levels.
- `key_valid`  out  1: a key event is held in the output register.
- `key_code`  out  4: index of the pressed button; valid only while `key_valid`=1.
- `key_ready`  in  1: consumer accepts the event this cycle.
- `multi_press`  out  1: 1-cycle pulse when ≥2 buttons are accepted as pressed on the same edge.
- `overrun`  out  1: 1-cycle pulse when a press event is dropped.

## Operation
- Per bit, the input passes through a 2-FF synchronizer (`sync1` → `sync2`), then a debouncer holding a `stable` level and counter `cnt`, width clog2(DEBOUNCE_CYCLES).
- Debouncer rules, evaluated each cycle:
  - `sync2` == `stable`: `cnt` ← 0.
  - Mismatch and `cnt` < DEBOUNCE_CYCLES-1: `cnt` increments.
  - Mismatch and `cnt` == DEBOUNCE_CYCLES-1: `stable` ← `sync2` and `cnt` ← 0.
- `pb_clean` = `stable`. Only rising transitions of `stable` are press events; releases generate nothing.
- Press vector `press` = next_stable & ~stable, combinational. `key_code` gets the lowest set index. Other simultaneous presses are discarded, and `multi_press` pulses if popcount(`press`) ≥ 2.
- The output register is a 1-entry buffer:
  - press present and (`!key_valid` or `key_ready`): load the code and set `key_valid`=1.
  - press present, `key_valid`=1 and `!key_ready`: keep the old code and pulse `overrun`.
  - no press and `key_ready`: `key_valid` ← 0.
- `key_code` stays stable while `key_valid`=1 and `!key_ready`.
- Reset values: `sync1`, `sync2`, `stable`, `cnt`, `pb_clean`, `key_valid`, `key_code`, `multi_press` and `overrun` are all 0.

## Timing
- Latency: a `pb_raw` rise set up before edge 0 and held steady gives `sync2`=1 after edge 2. `stable`/`pb_clean`=1 and `key_valid`=1 follow after edge 2+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 cycles.
- Bounce: any mismatch interrupted for even one cycle restarts `cnt` from 0. A glitch shorter than DEBOUNCE_CYCLES never changes `pb_clean`.
- Handshake: the event transfers on a cycle where `key_valid` and `key_ready` are both 1. `key_ready` with `key_valid`=0 has no effect.
- Simultaneous accept and new press: the new code loads, `key_valid` stays 1, and there is no `overrun`.
- `multi_press` and `overrun` can pulse in the same cycle.
- Reset mid-debounce or mid-handshake: all state clears at the next edge. A button held through reset is re-debounced and produces a fresh event DEBOUNCE_CYCLES+2 cycles after `nrst` deasserts.
- No combinational path from `pb_raw` or `key_ready` to any output.

## Structure
- Package `pb_pkg`: `PB_W`=10, `KEY_W`=4 and `DEBOUNCE_DEFAULT`=50000.
- Sub-module `pb_debounce`: one bit, holding the synchronizer, counter and stable level. It is instantiated NUM_PB times via generate.
- The top level holds the priority encoder, popcount check and output buffer.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and `key_ready` held 1 unless stated.
- Clean press: `pb_raw[3]` 0→1 held → `pb_clean[3]`=1 and `key_valid`=1 with `key_code`=3 after edge 6. The release 6 cycles later produces no event.
- Bounce: `pb_raw[5]` toggles 1,0,1,1,0,1 then holds 1 → exactly one event, code 5, accepted 4 cycles after the last toggle plus 2; glitches of ≤3 cycles are ignored.
- Simultaneous: `pb_raw[7]` and `pb_raw[2]` rise on the same edge → `key_code`=2 and `multi_press` pulses for 1 cycle.
- Backpressure: `key_ready`=0, press 1 then press 8 → `key_code` stays 1 and `overrun` pulses. Raising `key_ready` clears `key_valid` on the next edge.
- Accept plus new press: `key_valid`=1 with code 4, `key_ready`=1 in the same cycle as a press of 9 → `key_code`=9, `key_valid` stays 1, no `overrun`.
- Reset: assert `nrst`=0 mid-count with `pb_raw[0]` held 1 → all outputs 0. After release, `key_code`=0 is valid after edge 6.
